// File: rtl/psum_normalizer.sv
// Joins two signed partial-sum vectors and streams each element scaled by 256/total.
// Latency: first beat registered two edges after the edge that completes the pair; COL beats follow.
// Backpressure: none; valids seen while summing or streaming are dropped.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   s_valid_1 / psum_1    source-1 capture pulse and packed vector (element i = psum_1[i])
//   s_valid_2 / psum_2    source-2 capture pulse and packed vector
//   psum_norm_1/2         registered normalized elements of the current beat
//   norm_valid            high for exactly COL consecutive cycles per result
module psum_normalizer #(
    parameter int BW_PSUM = 16,
    parameter int COL     = 8,
    parameter int W_OUT   = BW_PSUM
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_valid_1,
    input  logic [COL-1:0][BW_PSUM-1:0]      psum_1,
    input  logic                             s_valid_2,
    input  logic [COL-1:0][BW_PSUM-1:0]      psum_2,
    output logic [W_OUT-1:0]                 psum_norm_1,
    output logic [W_OUT-1:0]                 psum_norm_2,
    output logic                             norm_valid
);

    // Total of 2*COL elements needs clog2(2*COL) guard bits.
    localparam int TW = BW_PSUM + $clog2(2 * COL);
    // Dividend is the element shifted left by 8 plus one sign bit.
    localparam int DW = BW_PSUM + 9;
    localparam int QW = (DW > TW) ? DW : TW;
    localparam int CW = $clog2(COL + 1);
    localparam int IW = (COL > 1) ? $clog2(COL) : 1;

    typedef enum logic [1:0] {
        COLLECT,
        SUM,
        OUT
    } state_t;

    state_t                         state;
    logic                           have_1;
    logic                           have_2;
    logic [COL-1:0][BW_PSUM-1:0]    vec_1;
    logic [COL-1:0][BW_PSUM-1:0]    vec_2;
    logic signed [TW-1:0]           total;
    logic [CW-1:0]                  cnt;
    logic signed [TW-1:0]           sum_c;
    logic [IW-1:0]                  idx;

    assign idx = cnt[IW-1:0];

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < COL; i++) begin
            sum_c = sum_c + TW'($signed(vec_1[i])) + TW'($signed(vec_2[i]));
        end
    end

    // Signed (elem*256)/tot, truncating toward zero; a zero total yields zero
    // instead of dividing by zero.
    function automatic logic [W_OUT-1:0] norm_elem(
        input logic [BW_PSUM-1:0] e,
        input logic signed [TW-1:0] tot
    );
        logic signed [QW-1:0] num;
        logic signed [QW-1:0] den;
        logic signed [QW-1:0] quo;
        num = QW'($signed(e));
        num = num <<< 8;
        den = QW'(tot);
        if (tot == '0) begin
            quo = '0;
        end else begin
            quo = num / den;
        end
        return quo[W_OUT-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            have_1      <= 1'b0;
            have_2      <= 1'b0;
            vec_1       <= '0;
            vec_2       <= '0;
            total       <= '0;
            cnt         <= '0;
            norm_valid  <= 1'b0;
            psum_norm_1 <= '0;
            psum_norm_2 <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (s_valid_1) begin
                        vec_1  <= psum_1;
                        have_1 <= 1'b1;
                    end
                    if (s_valid_2) begin
                        vec_2  <= psum_2;
                        have_2 <= 1'b1;
                    end
                    if ((have_1 || s_valid_1) && (have_2 || s_valid_2)) begin
                        state <= SUM;
                    end
                end
                SUM: begin
                    total <= sum_c;
                    cnt   <= '0;
                    state <= OUT;
                end
                OUT: begin
                    // cnt == COL is the edge after the last beat: drop valid,
                    // keep the last data on the outputs.
                    if (cnt == CW'(COL)) begin
                        norm_valid <= 1'b0;
                        have_1     <= 1'b0;
                        have_2     <= 1'b0;
                        state      <= COLLECT;
                    end else begin
                        norm_valid  <= 1'b1;
                        psum_norm_1 <= norm_elem(vec_1[idx], total);
                        psum_norm_2 <= norm_elem(vec_2[idx], total);
                        cnt         <= cnt + CW'(1);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_normalizer.sv
module tb_psum_normalizer;

    typedef logic [7:0][15:0] vec_t;
    typedef struct packed {
        logic [15:0] n1;
        logic [15:0] n2;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid_1;
    logic        s_valid_2;
    vec_t        psum_1;
    vec_t        psum_2;
    logic [15:0] psum_norm_1;
    logic [15:0] psum_norm_2;
    logic        norm_valid;

    beat_t sb[$];
    beat_t exp_b;
    beat_t last_b;
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    psum_normalizer #(.BW_PSUM(16), .COL(8), .W_OUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_1  (s_valid_1),
        .psum_1     (psum_1),
        .s_valid_2  (s_valid_2),
        .psum_2     (psum_2),
        .psum_norm_1(psum_norm_1),
        .psum_norm_2(psum_norm_2),
        .norm_valid (norm_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] norm(input logic [15:0] e, input int tot);
        int ev;
        int q;
        ev = int'($signed(e));
        if (tot == 0) return 16'h0000;
        q = (ev * 256) / tot;
        return q[15:0];
    endfunction

    task automatic push_expected(input vec_t a, input vec_t b);
        int tot;
        beat_t bt;
        tot = 0;
        for (int i = 0; i < 8; i++) tot += int'($signed(a[i])) + int'($signed(b[i]));
        for (int j = 0; j < 8; j++) begin
            bt.n1 = norm(a[j], tot);
            bt.n2 = norm(b[j], tot);
            sb.push_back(bt);
            last_b = bt;
        end
    endtask

    // Scoreboard monitor: every valid beat pops one expected entry.
    always @(negedge clk) begin
        if (norm_valid) begin
            check("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("norm_1", {16'h0, psum_norm_1}, {16'h0, exp_b.n1});
                check("norm_2", {16'h0, psum_norm_2}, {16'h0, exp_b.n2});
            end
        end
    end

    // Delivers a pair (first source, then the other gap cycles later; gap 0 =
    // same cycle) and checks the norm_valid window and output hold afterwards.
    // inject=1 pulses s_valid_1 with junk mid-stream, which must be dropped.
    task automatic run_pair(input vec_t a, input vec_t b, input int first, input int gap, input bit inject);
        push_expected(a, b);
        @(negedge clk);
        psum_1 = a;
        psum_2 = b;
        if (gap == 0) begin
            s_valid_1 = 1'b1;
            s_valid_2 = 1'b1;
        end else begin
            if (first == 1) s_valid_1 = 1'b1; else s_valid_2 = 1'b1;
            @(negedge clk);
            s_valid_1 = 1'b0;
            s_valid_2 = 1'b0;
            repeat (gap - 1) @(negedge clk);
            if (first == 1) s_valid_2 = 1'b1; else s_valid_1 = 1'b1;
        end
        @(negedge clk);               // after edge E
        s_valid_1 = 1'b0;
        s_valid_2 = 1'b0;
        check("nv_low_sum", {31'h0, norm_valid}, 32'd0);
        @(negedge clk);               // after E+1
        check("nv_low_e1", {31'h0, norm_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);           // after E+2+k
            check("nv_high", {31'h0, norm_valid}, 32'd1);
            if (inject && k == 2) begin
                psum_1    = {8{16'h7FFF}};
                s_valid_1 = 1'b1;
            end else begin
                s_valid_1 = 1'b0;
            end
        end
        s_valid_1 = 1'b0;
        @(negedge clk);               // after E+10
        check("nv_fall", {31'h0, norm_valid}, 32'd0);
        check("hold_1", {16'h0, psum_norm_1}, {16'h0, last_b.n1});
        check("hold_2", {16'h0, psum_norm_2}, {16'h0, last_b.n2});
    endtask

    initial begin
        vec_t a;
        vec_t b;
        vec_t z;
        int   waited;
        z         = '0;
        reset     = 1'b1;
        s_valid_1 = 1'b0;
        s_valid_2 = 1'b0;
        psum_1    = '0;
        psum_2    = '0;
        repeat (3) @(negedge clk);
        check("rst_nv", {31'h0, norm_valid}, 32'd0);
        check("rst_n1", {16'h0, psum_norm_1}, 32'd0);
        check("rst_n2", {16'h0, psum_norm_2}, 32'd0);
        reset = 1'b0;

        // Ramp with zeros, source 1 first, total 28.
        for (int i = 0; i < 8; i++) a[i] = 16'(i);
        run_pair(a, z, 1, 5, 1'b0);

        // Ramp with ones, source 2 first, total 36.
        for (int i = 0; i < 8; i++) b[i] = 16'd1;
        run_pair(a, b, 2, 12, 1'b0);

        // Same-cycle arrival with a negative element, total 8.
        a = '0; b = '0;
        a[0] = 16'hFFF8;
        b[0] = 16'd16;
        run_pair(a, b, 1, 0, 1'b0);

        // All zero: total 0 still streams eight zero beats.
        run_pair(z, z, 1, 3, 1'b0);

        // Repeated source-1 valid before source 2 overwrites the held vector.
        @(negedge clk);
        psum_1    = {8{16'h1234}};
        s_valid_1 = 1'b1;
        @(negedge clk);
        s_valid_1 = 1'b0;
        for (int i = 0; i < 8; i++) a[i] = 16'(3 * i + 1);
        for (int i = 0; i < 8; i++) b[i] = 16'(i);
        run_pair(a, b, 1, 2, 1'b0);

        // Reset during beat 3 aborts the result.
        for (int i = 0; i < 8; i++) a[i] = 16'(i + 2);
        push_expected(a, z);
        @(negedge clk);
        psum_1 = a; psum_2 = z;
        s_valid_1 = 1'b1; s_valid_2 = 1'b1;
        @(negedge clk);
        s_valid_1 = 1'b0; s_valid_2 = 1'b0;
        repeat (5) @(negedge clk);    // beats 0..3 observed
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_nv", {31'h0, norm_valid}, 32'd0);
        check("abort_n1", {16'h0, psum_norm_1}, 32'd0);
        check("abort_n2", {16'h0, psum_norm_2}, 32'd0);
        for (int i = 0; i < 8; i++) a[i] = 16'(5 * i);
        run_pair(a, z, 2, 1, 1'b0);

        // Valid during OUT is dropped; the next pair (source 2 first) must wait for source 1.
        for (int i = 0; i < 8; i++) a[i] = 16'(10 - i);
        for (int i = 0; i < 8; i++) b[i] = 16'(i * 2);
        run_pair(a, b, 1, 1, 1'b1);
        for (int i = 0; i < 8; i++) a[i] = 16'(i + 7);
        run_pair(a, b, 2, 4, 1'b0);

        // Random pairs with random order and gaps.
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 8; i++) begin
                a[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
                b[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
            end
            run_pair(a, b, int'($urandom_range(1, 2)), int'($urandom_range(0, 6)), 1'b0);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
